// File: rtl/mc_ctrl_fsm_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle main control unit.
// Holds the state encoding, opcode values, ALUOp codes, datapath mux select
// codes, the packed control vector produced by the output decoder, and a
// helper that classifies opcodes as legal or illegal.
package ctrl_pkg;

    // The state encoding is visible on state_o, so the values are fixed.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [3:0] OPC_RTYPE = 4'b0000;
    localparam logic [3:0] OPC_LW    = 4'b0001;
    localparam logic [3:0] OPC_SW    = 4'b0010;
    localparam logic [3:0] OPC_BEQ   = 4'b0011;
    localparam logic [3:0] OPC_ADDI  = 4'b0100;
    localparam logic [3:0] OPC_ORI   = 4'b0101;
    localparam logic [3:0] OPC_J     = 4'b0110;
    // Stand-in code for anything outside the defined instruction set.
    localparam logic [3:0] OPC_BAD   = 4'b1111;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OPC_J;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: bundle between the control unit and the datapath.
//   opcode, mem_ready            : datapath -> control
//   control strobes / selects    : control -> datapath
//   state_o, illegal, retired    : control status for debug/monitoring
// Modports: slave = control unit, master = datapath (or testbench).
interface mc_ctrl_fsm_if #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
);
    logic [OP_W-1:0]  opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             branch;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [1:0]       alu_op;
    logic [3:0]       state_o;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  opcode, mem_ready,
        output pc_write, branch, iord, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
               pc_src, alu_op, state_o, illegal, retired
    );

    modport master (
        output opcode, mem_ready,
        input  pc_write, branch, iord, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
               pc_src, alu_op, state_o, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm_outdec.sv
// mc_ctrl_outdec: purely combinational control-vector decode.
//   state     : current FSM state
//   opc       : normalised 4-bit opcode (selects ADD vs OR in IMMEX)
//   mem_ready : gates ir_write/pc_write in FETCH only
//   ctrl      : full datapath control vector, all zero unless asserted below
module mc_ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opc,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                // Only latch the instruction and advance PC once memory delivers.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_SHIMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opc == OPC_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle main control unit.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mc_ctrl_fsm_if (opcode/mem_ready in, control
//           strobes, ALUOp, state_o, sticky illegal flag, retired count out)
// Holds the state register, next-state logic, retired-instruction counter
// and illegal-opcode flag; output decode lives in mc_ctrl_outdec.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int OP_W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.slave  bus
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             illegal_reg;
    logic             retire;
    logic             set_illegal;
    logic [3:0]       opc;
    ctrl_t            ctrl;

    // Collapse the opcode to 4 bits; wider opcodes with any upper bit set
    // are treated as illegal rather than aliasing onto a real instruction.
    always_comb begin
        opc = OPC_BAD;
        if (((bus.opcode >> 4) == '0) && op_is_legal(bus.opcode[3:0]))
            opc = bus.opcode[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        retire      = 1'b0;
        set_illegal = 1'b0;
        unique case (state_reg)
            IDLE:   state_next = FETCH;
            FETCH:  if (bus.mem_ready) state_next = DECODE;
            DECODE: begin
                unique case (opc)
                    OPC_RTYPE:         state_next = EXEC;
                    OPC_LW, OPC_SW:    state_next = MEMADR;
                    OPC_BEQ:           state_next = BRANCH;
                    OPC_ADDI, OPC_ORI: state_next = IMMEX;
                    OPC_J:             state_next = JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = FETCH;
                    end
                endcase
            end
            MEMADR: state_next = (opc == OPC_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) state_next = MEMWB;
            MEMWR: begin
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC:   state_next = ALUWB;
            IMMEX:  state_next = IMMWB;
            MEMWB, ALUWB, BRANCH, IMMWB, JUMP: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter wraps naturally; the illegal flag only clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
            if (set_illegal)
                illegal_reg <= 1'b1;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_reg),
        .opc       (opc),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.branch     = ctrl.branch;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.state_o    = state_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.retired    = retired_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm. Outputs are sampled 1 time unit after
// each rising edge; expected state codes and control vectors are written out
// by hand below. Control vector bit order:
//   {pc_write, branch, iord, mem_read, mem_write, ir_write, reg_write,
//    mem_to_reg, reg_dst, alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[1:0]}
module tb_mc_ctrl_fsm;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                           S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                           S_MEMWR = 4'd6, S_EXEC = 4'd7,  S_ALUWB = 4'd8,
                           S_BRANCH = 4'd9, S_IMMEX = 4'd10, S_IMMWB = 4'd11,
                           S_JUMP = 4'd12;

    localparam logic [15:0] V_ZERO      = 16'h0000;
    localparam logic [15:0] V_FETCH     = {10'b1001010000, 2'b01, 2'b00, 2'b10};
    localparam logic [15:0] V_FETCHW    = {10'b0001000000, 2'b01, 2'b00, 2'b10};
    localparam logic [15:0] V_DECODE    = {10'b0000000000, 2'b11, 2'b00, 2'b10};
    localparam logic [15:0] V_MEMADR    = {10'b0000000001, 2'b10, 2'b00, 2'b10};
    localparam logic [15:0] V_MEMRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_MEMWB     = {10'b0000001100, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_MEMWR     = {10'b0010100000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_EXEC      = {10'b0000000001, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_ALUWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_BRANCH    = {10'b0100000001, 2'b00, 2'b01, 2'b01};
    localparam logic [15:0] V_IMMEX_OR  = {10'b0000000001, 2'b10, 2'b00, 2'b11};
    localparam logic [15:0] V_IMMEX_ADD = {10'b0000000001, 2'b10, 2'b00, 2'b10};
    localparam logic [15:0] V_IMMWB     = {10'b0000001000, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] V_JUMP      = {10'b1000000000, 2'b00, 2'b10, 2'b00};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    mc_ctrl_fsm_if #(.OP_W(4), .CNT_W(16)) bus ();

    mc_ctrl_fsm #(.CNT_W(16), .OP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] outs();
        return {bus.pc_write, bus.branch, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.reg_dst,
                bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.opcode = 4'b0000;
        bus.mem_ready = 1'b1;
        step();
        step();
        n_cmp++; if (bus.state_o !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state_o, S_IDLE); end
        n_cmp++; if (outs() !== V_ZERO) begin n_err++; $display("FAIL reset_outs: got %h want %h", outs(), V_ZERO); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL reset_to_fetch: got %0d want %0d", bus.state_o, S_FETCH); end
        $display("reset: done");
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4] = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
        logic [15:0] ev [4] = '{V_FETCH, V_DECODE, V_EXEC, V_ALUWB};
        bus.opcode = 4'b0000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.state_o !== es[i]) begin n_err++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, bus.state_o, es[i]); end
            n_cmp++; if (outs() !== ev[i]) begin n_err++; $display("FAIL rtype_outs[%0d]: got %h want %h", i, outs(), ev[i]); end
            if (i == 3) begin
                n_cmp++; if (bus.retired !== 16'd0) begin n_err++; $display("FAIL rtype_retired_before: got %0d want 0", bus.retired); end
            end
            step();
        end
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL rtype_end: got %0d want %0d", bus.state_o, S_FETCH); end
        n_cmp++; if (bus.retired !== 16'd1) begin n_err++; $display("FAIL rtype_retired: got %0d want 1", bus.retired); end
        $display("rtype: retired=%0d", bus.retired);
    endtask

    task automatic test_lw_stall();
        logic [3:0]  es [7] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        logic [15:0] ev [7] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = mr[i];
            #1;
            n_cmp++; if (bus.state_o !== es[i]) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_o, es[i]); end
            n_cmp++; if (outs() !== ev[i]) begin n_err++; $display("FAIL lw_outs[%0d]: got %h want %h", i, outs(), ev[i]); end
            step();
        end
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL lw_end: got %0d want %0d", bus.state_o, S_FETCH); end
        n_cmp++; if (bus.retired !== 16'd2) begin n_err++; $display("FAIL lw_retired: got %0d want 2", bus.retired); end
        $display("lw_stall: 7 cycles, retired=%0d", bus.retired);
    endtask

    task automatic test_sw_fetch_stall();
        logic [3:0]  es [6] = '{S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR};
        logic [15:0] ev [6] = '{V_FETCHW, V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR};
        logic        mr [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.opcode = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = mr[i];
            #1;
            n_cmp++; if (bus.state_o !== es[i]) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.state_o, es[i]); end
            n_cmp++; if (outs() !== ev[i]) begin n_err++; $display("FAIL sw_outs[%0d]: got %h want %h", i, outs(), ev[i]); end
            if (i == 4) begin
                n_cmp++; if (bus.retired !== 16'd2) begin n_err++; $display("FAIL sw_retired_stalled: got %0d want 2", bus.retired); end
            end
            step();
        end
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL sw_end: got %0d want %0d", bus.state_o, S_FETCH); end
        n_cmp++; if (bus.retired !== 16'd3) begin n_err++; $display("FAIL sw_retired: got %0d want 3", bus.retired); end
        $display("sw_fetch_stall: retired=%0d", bus.retired);
    endtask

    task automatic test_illegal_then_jump();
        bus.mem_ready = 1'b1;
        bus.opcode = 4'b1111;
        step();
        n_cmp++; if (bus.state_o !== S_DECODE) begin n_err++; $display("FAIL ill_decode: got %0d want %0d", bus.state_o, S_DECODE); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL ill_early: got %b want 0", bus.illegal); end
        step();
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL ill_to_fetch: got %0d want %0d", bus.state_o, S_FETCH); end
        n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL ill_set: got %b want 1", bus.illegal); end
        n_cmp++; if (bus.retired !== 16'd3) begin n_err++; $display("FAIL ill_no_retire: got %0d want 3", bus.retired); end
        bus.opcode = 4'b0110;
        step();
        step();
        n_cmp++; if (bus.state_o !== S_JUMP) begin n_err++; $display("FAIL j_state: got %0d want %0d", bus.state_o, S_JUMP); end
        n_cmp++; if (outs() !== V_JUMP) begin n_err++; $display("FAIL j_outs: got %h want %h", outs(), V_JUMP); end
        step();
        n_cmp++; if (bus.retired !== 16'd4) begin n_err++; $display("FAIL j_retired: got %0d want 4", bus.retired); end
        n_cmp++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL ill_sticky: got %b want 1", bus.illegal); end
        $display("illegal_then_jump: illegal=%b retired=%0d", bus.illegal, bus.retired);
    endtask

    task automatic test_reset_mid_memrd();
        bus.opcode = 4'b0001;
        bus.mem_ready = 1'b1;
        step();
        step();
        step();
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.state_o !== S_MEMRD) begin n_err++; $display("FAIL mr_pre_state: got %0d want %0d", bus.state_o, S_MEMRD); end
        step();
        rst_n = 1'b0;
        step();
        n_cmp++; if (bus.state_o !== S_IDLE) begin n_err++; $display("FAIL mr_rst_state: got %0d want %0d", bus.state_o, S_IDLE); end
        n_cmp++; if (outs() !== V_ZERO) begin n_err++; $display("FAIL mr_rst_outs: got %h want %h", outs(), V_ZERO); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_err++; $display("FAIL mr_rst_retired: got %0d want 0", bus.retired); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL mr_rst_illegal: got %b want 0", bus.illegal); end
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        n_cmp++; if (bus.state_o !== S_FETCH) begin n_err++; $display("FAIL mr_rst_fetch: got %0d want %0d", bus.state_o, S_FETCH); end
        $display("reset_mid_memrd: done");
    endtask

    task automatic test_back_to_back();
        // BEQ, ORI, then ADDI with stray mem_ready lows outside wait states.
        logic [3:0]  es [11] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_IMMEX,
                                 S_IMMWB, S_FETCH, S_DECODE, S_IMMEX, S_IMMWB};
        logic [15:0] ev [11] = '{V_FETCH, V_DECODE, V_BRANCH, V_FETCH, V_DECODE, V_IMMEX_OR,
                                 V_IMMWB, V_FETCH, V_DECODE, V_IMMEX_ADD, V_IMMWB};
        logic [3:0]  op [11] = '{4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd4, 4'd4, 4'd4, 4'd4};
        logic        mr [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.opcode = op[i];
            bus.mem_ready = mr[i];
            #1;
            n_cmp++; if (bus.state_o !== es[i]) begin n_err++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, bus.state_o, es[i]); end
            n_cmp++; if (outs() !== ev[i]) begin n_err++; $display("FAIL b2b_outs[%0d]: got %h want %h", i, outs(), ev[i]); end
            if (i == 6) begin
                n_cmp++; if (bus.retired !== 16'd1) begin n_err++; $display("FAIL b2b_retired_mid: got %0d want 1", bus.retired); end
            end
            step();
        end
        n_cmp++; if (bus.retired !== 16'd3) begin n_err++; $display("FAIL b2b_retired: got %0d want 3", bus.retired); end
        bus.mem_ready = 1'b1;
        $display("back_to_back: retired=%0d", bus.retired);
    endtask

    task automatic test_wrap();
        bus.opcode = 4'b0110;
        bus.mem_ready = 1'b1;
        force dut.retired_reg = 16'hFFFE;
        step();
        step();
        release dut.retired_reg;
        n_cmp++; if (bus.state_o !== S_JUMP) begin n_err++; $display("FAIL wrap_j1_state: got %0d want %0d", bus.state_o, S_JUMP); end
        step();
        n_cmp++; if (bus.retired !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max: got %h want ffff", bus.retired); end
        step();
        step();
        step();
        n_cmp++; if (bus.retired !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", bus.retired); end
        $display("wrap: retired=%h", bus.retired);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_fetch_stall();
        test_illegal_then_jump();
        test_reset_mid_memrd();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
